// File: rtl/fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_arbiter
// Purpose  : Shares one pipelined IEEE-754 single-precision add/sub unit of
//            fixed latency among NUM_REQ requesters. Grants one request per
//            cycle (round-robin), registers the winner's operands onto the
//            unit, carries the requester ID down a tag pipeline matched to the
//            unit latency and returns each result as a one-cycle, one-hot
//            response pulse. Operand data is never inspected.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_a/req_b/req_op : requester handshake
//            fpu_a/fpu_b/fpu_operation_select/fpu_in_valid : to the unit
//            fpu_result : from the unit, FPU_LAT cycles after its inputs
//            rsp_valid/rsp_id/rsp_result : response (no backpressure)
// Options  : FP_ARB_FIXED_PRIO_EN - when defined, fixed priority (lowest
//            index wins) replaces round-robin and the pointer is removed.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int FPU_LAT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    input  logic [NUM_REQ-1:0]           req_op,
    output logic [WIDTH-1:0]             fpu_a,
    output logic [WIDTH-1:0]             fpu_b,
    output logic                         fpu_operation_select,
    output logic                         fpu_in_valid,
    input  logic [WIDTH-1:0]             fpu_result,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]             rsp_result
);

    localparam int                 c_ID_W  = $clog2(NUM_REQ);
    // One extra bit so ptr + offset cannot overflow before the modulo wrap.
    localparam int                 c_IDX_W = c_ID_W + 1;
    localparam logic [NUM_REQ-1:0] c_ONE   = NUM_REQ'(1);

    logic [NUM_REQ-1:0] r_busy;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any_grant;
    logic [c_ID_W-1:0]  w_gnt_id;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_ID_W-1:0]  w_ptr;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_sel_op;
    logic [c_ID_W-1:0]  r_in_id;
    logic               w_tag_out_v;
    logic [c_ID_W-1:0]  w_tag_out_id;
    logic [NUM_REQ-1:0] w_clr;

    // ------------------------------------------------------------------------
    // Search start pointer
    // ------------------------------------------------------------------------
`ifdef FP_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [c_ID_W-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any_grant) begin
            r_ptr <= (w_gnt_id == c_ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    // ------------------------------------------------------------------------
    // Grant: first eligible index at or after the pointer, wrapping.
    // ------------------------------------------------------------------------
    assign w_elig = req_valid & ~r_busy;

    always_comb begin
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_gnt_id    = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, w_ptr} + c_IDX_W'(k);
            if (w_idx >= c_IDX_W'(NUM_REQ)) begin
                w_idx = w_idx - c_IDX_W'(NUM_REQ);
            end
            if (!w_any_grant && w_elig[w_idx[c_ID_W-1:0]]) begin
                w_any_grant                  = 1'b1;
                w_gnt_id                     = w_idx[c_ID_W-1:0];
                w_grant[w_idx[c_ID_W-1:0]]   = 1'b1;
            end
        end
    end

    // Operand select from the one-hot grant (constant slices per requester).
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a  = req_a[i*WIDTH +: WIDTH];
                w_sel_b  = req_b[i*WIDTH +: WIDTH];
                w_sel_op = req_op[i];
            end
        end
    end

    // Ready is masked while reset is held so nothing is accepted into a
    // pipeline that is being cleared.
    assign req_ready = w_grant & {NUM_REQ{~rst}};

    // ------------------------------------------------------------------------
    // Unit input stage. The operands hold between accepts; only the valid
    // bit and the input-stage tag move on idle cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a                <= '0;
            fpu_b                <= '0;
            fpu_operation_select <= 1'b0;
            fpu_in_valid         <= 1'b0;
            r_in_id              <= '0;
        end else begin
            fpu_in_valid <= w_any_grant;
            if (w_any_grant) begin
                fpu_a                <= w_sel_a;
                fpu_b                <= w_sel_b;
                fpu_operation_select <= w_sel_op;
                r_in_id              <= w_gnt_id;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag pipeline: {fpu_in_valid, r_in_id} is the tag aligned with the unit
    // inputs; it is delayed FPU_LAT cycles so it emerges with fpu_result.
    // ------------------------------------------------------------------------
    generate
        if (FPU_LAT == 0) begin : g_lat0
            assign w_tag_out_v  = fpu_in_valid;
            assign w_tag_out_id = r_in_id;
        end else begin : g_latn
            logic [FPU_LAT-1:0] r_tag_v;
            logic [c_ID_W-1:0]  r_tag_id [FPU_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_v <= '0;
                    for (int s = 0; s < FPU_LAT; s++) begin
                        r_tag_id[s] <= '0;
                    end
                end else begin
                    r_tag_v[0]  <= fpu_in_valid;
                    r_tag_id[0] <= r_in_id;
                    for (int s = 1; s < FPU_LAT; s++) begin
                        r_tag_v[s]  <= r_tag_v[s-1];
                        r_tag_id[s] <= r_tag_id[s-1];
                    end
                end
            end

            assign w_tag_out_v  = r_tag_v[FPU_LAT-1];
            assign w_tag_out_id = r_tag_id[FPU_LAT-1];
        end
    endgenerate

    // Requester whose response is raised at the coming edge.
    assign w_clr = w_tag_out_v ? (c_ONE << w_tag_out_id) : '0;

    // ------------------------------------------------------------------------
    // Busy flags and response registers. A requester can never be granted
    // while busy, so set and clear never collide on the same bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            rsp_valid  <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            r_busy    <= (r_busy & ~w_clr) | w_grant;
            rsp_valid <= w_clr;
            if (w_tag_out_v) begin
                rsp_id     <= w_tag_out_id;
                rsp_result <= fpu_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Shares one pipelined FP add/sub unit (IEEE-754 single precision, fixed latency) among NUM_REQ requesters. Each requester issues an operand pair and an operation over a valid/ready handshake. The block arbitrates round-robin, drives the unit's a/b/operation_select inputs, and tracks in-flight requester IDs through a tag pipeline matched to the unit latency. It routes each result back as a one-cycle response tagged with the requester ID, and sits between the requester-side fabric and the add/sub datapath.

## Interface
- WIDTH, 32: operand/result width
- NUM_REQ, 4: number of requesters (2..8)
- FPU_LAT, 3: unit latency in cycles from inputs applied to result valid (0 = combinational)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  request valid, per requester
- req_ready  out  NUM_REQ  request accepted this cycle, per requester
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a
- req_op  in  NUM_REQ  operation: 0 = add, 1 = subtract
- fpu_a  out  WIDTH  operand A to the unit
- fpu_b  out  WIDTH  operand B to the unit
- fpu_operation_select  out  1  operation to the unit
- fpu_in_valid  out  1  fpu_a, fpu_b and fpu_operation_select carry a live operation
- fpu_result  in  WIDTH  unit result, valid FPU_LAT cycles after its inputs
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: response for requester i
- rsp_id  out  $clog2(NUM_REQ)  requester index of the current response
- rsp_result  out  WIDTH  result data

## Operation
- busy[i] flag: each requester has at most one operation outstanding.
  - Set on accept.
  - Cleared at the edge that raises rsp_valid[i].
- Eligible requesters: req_valid[i] & ~busy[i].
- Round-robin grant:
  - Search starts at ptr and wraps modulo NUM_REQ.
  - The first eligible index is granted.
  - At most one grant per cycle.
- req_ready[i] is combinational: grant[i] & ~rst. It never asserts for a busy requester.
- Accept = req_valid[i] & req_ready[i]. On accept of requester g:
  - Register req_a[g], req_b[g] and req_op[g] onto fpu_a, fpu_b and fpu_operation_select.
  - Set fpu_in_valid.
  - Push {valid=1, id=g} into the tag pipeline.
  - Set ptr to (g+1) mod NUM_REQ.
- Cycle with no accept:
  - fpu_in_valid = 0.
  - fpu_a, fpu_b and fpu_operation_select hold their last values.
  - A bubble tag is pushed.
  - ptr holds.
- Tag pipeline depth is FPU_LAT; it advances every cycle. A tag emerging with valid=1:
  - Capture fpu_result into rsp_result.
  - Capture the tag id into rsp_id.
  - Pulse rsp_valid[id] for one cycle.
- Response side has no backpressure. Requesters must sink responses.
- rsp_result and rsp_id hold their values between pulses.
- Operand contents (NaN, inf, denormal, zero) are passed through untouched. The arbiter never inspects data.

## Timing
- Reset values (async on rst):
  - fpu_a, fpu_b, rsp_result = 0; fpu_operation_select = 0; fpu_in_valid = 0.
  - rsp_valid = 0; rsp_id = 0.
  - busy = 0; ptr = 0; all tags invalid.
- Accept in cycle T:
  - fpu_in_valid = 1 in cycle T+1.
  - rsp_valid in cycle T+FPU_LAT+2, so total latency is FPU_LAT+2.
- Throughput: one accept per cycle across distinct requesters. Per requester, the next accept can occur no earlier than the rsp_valid cycle, because busy clears at that edge.
- Simultaneous events in one cycle: response to i, accept of j≠i, and new req_valid[i].
  - All legal.
  - Requester i is eligible in the rsp_valid cycle.
- Reset mid-operation:
  - In-flight tags are discarded; no responses are emitted for them.
  - Results still emerging from the unit after reset are ignored.
- req_valid dropped before ready: no accept, no state change.

## Configuration
- FP_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. ptr is not implemented and is treated as constant 0.
  - Undefined (default): round-robin as above.

## Test plan
- Bench: FPU_LAT=3, NUM_REQ=4, with the real add/sub unit or a reference stub.
- Single add:
  - Stimulus: req 0, a=0x3F800000, b=0x40000000, op=0, accepted in cycle 5.
  - Response: fpu_in_valid in cycle 6; rsp_valid=4'b0001, rsp_id=0, rsp_result=0x40400000 in cycle 10.
- Subtract:
  - Stimulus: req 2, a=0x40400000, b=0x3F800000, op=1.
  - Response: rsp_valid=4'b0100, rsp_id=2, rsp_result=0x40000000, 5 cycles after accept.
- All four requesters valid continuously from reset:
  - Grant order is 0,1,2,3, one per cycle.
  - Each requester is re-granted only from its own rsp_valid cycle onward, following the round-robin order.
  - With FP_ARB_FIXED_PRIO_EN defined, req 0 wins every cycle in which it is eligible.
- Busy blocking: requester 1 holds req_valid after accept. req_ready[1] stays 0 until its rsp_valid cycle, then reasserts in that cycle.
- Reset mid-flight: accept requests for 0 and 1, assert rst two cycles later. No rsp_valid pulses occur, and all outputs read their reset values.
- Special values: req 3, a=0x7FC00000 (NaN), b=0x3F800000. Accepted, with rsp_result equal to fpu_result unmodified.
